// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-memory responder: bus widths and the
// response record carried through the response queue.
package imem_responder_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [ILEN-1:0] data;
        logic            err;
    } imem_rsp_t;

    localparam imem_rsp_t RSP_NONE = '0;

    // Faulting fetches never leak memory contents onto rsp_data.
    function automatic imem_rsp_t make_rsp(input logic [ILEN-1:0] word, input logic err);
        imem_rsp_t r;
        r.data = err ? '0 : word;
        r.err  = err;
        return r;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small circular response queue; the head entry is visible combinationally
// from registered storage so the consumer sees it as soon as it is written.
module imem_rsp_fifo
    import imem_responder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rsp_t = imem_rsp_t,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output rsp_t          head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t          entry_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload needs no reset: slots are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = entry_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder: word-addressed program memory with a
// registered read, feeding an in-order response queue with backpressure.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int RSP_DEPTH   = 4,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ILEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_idx,
    input  logic [ILEN-1:0] ld_data
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [ILEN-1:0] mem [DEPTH_WORDS];

    logic [ILEN-1:0] rd_word_reg;
    logic            rd_err_reg;
    logic            inflight_reg, inflight_next;

    logic [XLEN-3:0] req_index;
    logic            req_bad;
    logic            accept;
    logic            ld_ok;

    imem_rsp_t       inflight_rsp;
    imem_rsp_t       fifo_head;
    imem_rsp_t       head_rsp;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            pop;
    logic [CW:0]     occupancy;

    assign req_index = req_addr[XLEN-1:2];
    assign req_bad   = (req_addr[1:0] != 2'b00) || (req_index >= (XLEN-2)'(DEPTH_WORDS));
    assign accept    = req_valid && req_ready;

    // A power-of-two depth makes every ld_idx legal; otherwise trim the top.
    generate
        if (DEPTH_WORDS == (1 << AW)) begin : g_ld_full
            assign ld_ok = 1'b1;
        end else begin : g_ld_trim
            assign ld_ok = ({1'b0, ld_idx} < (AW+1)'(DEPTH_WORDS));
        end
    endgenerate

    // Program load is independent of reset so code survives a core restart.
    always_ff @(posedge clk) begin
        if (ld_we && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Read-first: a load to the same word on this edge is not yet visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_reg <= mem[req_addr[AW+1:2]];
            rd_err_reg  <= req_bad;
        end
    end

    assign inflight_next = accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign inflight_rsp = make_rsp(rd_word_reg, rd_err_reg);
    assign fifo_empty   = (fifo_count == '0);

    // The in-flight read is always the youngest response, so it is the head
    // only when the queue is empty; then it may be consumed without queueing.
    always_comb begin
        head_rsp = RSP_NONE;
        if (!fifo_empty) begin
            head_rsp = fifo_head;
        end else if (inflight_reg) begin
            head_rsp = inflight_rsp;
        end
    end

    assign rsp_valid = !fifo_empty || inflight_reg;
    assign rsp_data  = head_rsp.data;
    assign rsp_err   = head_rsp.err;

    assign pop       = rsp_valid && rsp_ready;
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = inflight_reg && !(pop && fifo_empty);

    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_reg);
    assign req_ready = (occupancy < (CW+1)'(RSP_DEPTH));

    imem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .rsp_t (imem_rsp_t),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (inflight_rsp),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Scenario bench for imem_responder: expected responses are queued as
// requests are accepted and retired against every rsp handshake.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    int total_checks  = 0;
    int passed_checks = 0;

    imem_rsp_t   sb[$];
    imem_rsp_t   mon_exp;
    logic [31:0] model_mem [DEPTH_WORDS];
    logic [31:0] prog [4];

    imem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake retires the oldest expected response.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            total_checks++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected got data=%h err=%b want no response", rsp_data, rsp_err);
            end else begin
                mon_exp = sb.pop_front();
                if ({rsp_data, rsp_err} !== {mon_exp.data, mon_exp.err}) begin
                    $display("FAIL rsp_order got data=%h err=%b want data=%h err=%b",
                             rsp_data, rsp_err, mon_exp.data, mon_exp.err);
                end else begin
                    passed_checks++;
                    $display("rsp data=%h err=%b", rsp_data, rsp_err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic imem_rsp_t model_rsp(input logic [63:0] addr);
        imem_rsp_t   r;
        logic [61:0] idx;
        logic [1:0]  lo;
        idx = addr[63:2];
        lo  = addr[1:0];
        r.err  = (lo != 2'b00) || (idx >= 62'(DEPTH_WORDS));
        r.data = r.err ? 32'h0 : model_mem[idx[9:0]];
        return r;
    endfunction

    // Presents a request for the coming edge; queues its expectation if it will be taken.
    task automatic drive_req(input logic [63:0] addr, output logic accepted);
        req_valid = 1'b1;
        req_addr  = addr;
        accepted  = req_ready;
        if (accepted) sb.push_back(model_rsp(addr));
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = 10'(idx);
        ld_data = data;
        tick();
        ld_we = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic wait_drain(output logic drained);
        drained = 1'b0;
        for (int c = 0; c < 64 && !drained; c++) begin
            if (sb.size() == 0 && !rsp_valid) drained = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total_checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== 34'h0)
            $display("FAIL reset_outputs got valid=%b data=%h err=%b want 0/0/0", rsp_valid, rsp_data, rsp_err);
        else passed_checks++;
        reset = 1'b1;
        tick();
        total_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
        else passed_checks++;
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic drained;
        prog[0] = 32'h00000013; prog[1] = 32'h00100093;
        prog[2] = 32'h00200113; prog[3] = 32'h00300193;
        for (int i = 0; i < 4; i++) load_word(i, prog[i]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(64'(i * 4), ok);
            total_checks++;
            if (ok !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, ok);
            else passed_checks++;
            tick();
            total_checks++;
            if (rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, rsp_valid);
            else passed_checks++;
        end
        req_valid = 1'b0;
        tick();
        total_checks++;
        if (rsp_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL b2b_done got valid=%b pending=%0d want 0/0", rsp_valid, sb.size());
        else passed_checks++;
        wait_drain(drained);
        $display("test_back_to_back done");
    endtask

    task automatic test_errors();
        logic ok;
        logic drained;
        logic [63:0] addrs [5];
        load_word(1023, 32'hA5A50FFC);
        addrs[0] = 64'h6;
        addrs[1] = 64'h4;
        addrs[2] = 64'h1000;
        addrs[3] = 64'hFFC;
        addrs[4] = 64'h8000_0000_0000_0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(addrs[i], ok);
            tick();
            req_valid = 1'b0;
            wait_drain(drained);
            total_checks++;
            if (!drained) $display("FAIL err_drain[%0d] got pending=%0d want 0", i, sb.size());
            else passed_checks++;
        end
        $display("test_errors done");
    endtask

    task automatic test_backpressure();
        logic ok;
        logic drained;
        int   acc = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_req(64'((k % 4) * 4), ok);
            if (ok) acc++;
            tick();
        end
        req_valid = 1'b0;
        total_checks++;
        if (acc != 4) $display("FAIL bp_accepted got %0d want 4", acc);
        else passed_checks++;
        for (int k = 0; k < 3; k++) begin
            total_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== model_mem[0])
                $display("FAIL bp_stall[%0d] got ready=%b valid=%b data=%h want 0/1/%h",
                         k, req_ready, rsp_valid, rsp_data, model_mem[0]);
            else passed_checks++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total_checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_ready_return got %b want 1", req_ready);
        else passed_checks++;
        wait_drain(drained);
        total_checks++;
        if (!drained) $display("FAIL bp_drain got pending=%0d want 0", sb.size());
        else passed_checks++;
        $display("test_backpressure done");
    endtask

    task automatic test_load_collision();
        logic ok;
        logic drained;
        rsp_ready = 1'b1;
        ld_we   = 1'b1;
        ld_idx  = 10'd2;
        ld_data = 32'hDEADBEEF;
        drive_req(64'h8, ok);
        tick();
        ld_we = 1'b0;
        req_valid = 1'b0;
        model_mem[2] = 32'hDEADBEEF;
        total_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL coll_latency got %b want 1", rsp_valid);
        else passed_checks++;
        wait_drain(drained);
        drive_req(64'h8, ok);
        tick();
        req_valid = 1'b0;
        wait_drain(drained);
        total_checks++;
        if (!drained) $display("FAIL coll_drain got pending=%0d want 0", sb.size());
        else passed_checks++;
        $display("test_load_collision done");
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        logic drained;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_req(64'(k * 4), ok);
            tick();
        end
        req_valid = 1'b0;
        total_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL mid_pending got %b want 1", rsp_valid);
        else passed_checks++;
        reset = 1'b0;
        sb.delete();
        ld_we   = 1'b1;
        ld_idx  = 10'd5;
        ld_data = 32'h00000055;
        tick();
        reset = 1'b1;
        ld_we = 1'b0;
        model_mem[5] = 32'h00000055;
        total_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL mid_reset got valid=%b ready=%b data=%h err=%b want 0/1/0/0",
                     rsp_valid, req_ready, rsp_data, rsp_err);
        else passed_checks++;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        total_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL mid_stale got %b want 0", rsp_valid);
        else passed_checks++;
        drive_req(64'h0, ok);
        tick();
        drive_req(64'h14, ok);
        tick();
        req_valid = 1'b0;
        wait_drain(drained);
        total_checks++;
        if (!drained) $display("FAIL mid_drain got pending=%0d want 0", sb.size());
        else passed_checks++;
        $display("test_reset_mid_op done");
    endtask

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = 32'h0;
        test_reset();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_load_collision();
        test_reset_mid_op();
        total_checks++;
        if (sb.size() != 0) $display("FAIL sb_empty got %0d want 0", sb.size());
        else passed_checks++;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit instruction words stored.
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4, giving the response queue entries, in-flight read included.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low: asserted when 0, sampled on the rising clk edge.
REQ-005 req_valid  input  1  the fetch address is valid.
REQ-006 req_ready  output  1  the block accepts a fetch this cycle.
REQ-007 req_addr  input  64  the byte address from the PC.
REQ-008 rsp_valid  output  1  the head response is valid.
REQ-009 rsp_ready  input  1  the consumer takes the head response.
REQ-010 rsp_data  output  32  the instruction word.
REQ-011 rsp_err  output  1  the fetch was misaligned or out of range.
REQ-012 ld_we  input  1  write strobe for program load.
REQ-013 ld_idx  input  clog2(DEPTH_WORDS)  the word index for program load.
REQ-014 ld_data  input  32  the word to load.

Function
REQ-015 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-016 req_ready SHALL be 1 when (queued entries + in-flight reads) < RSP_DEPTH, registered state only, with no combinational path from rsp_ready or req_valid.
REQ-017 An accepted request SHALL be read on the next edge and its response SHALL reach the queue one cycle after acceptance; when the queue was empty, rsp_valid SHALL be 1 in the cycle after the acceptance edge.
REQ-018 Responses SHALL be returned in acceptance order; none SHALL be dropped or duplicated except on reset.
REQ-019 The head response SHALL pop on an edge where rsp_valid=1 and rsp_ready=1.
REQ-020 rsp_data, rsp_err and rsp_valid SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-021 Word index SHALL be req_addr[63:2].
REQ-022 When req_addr[1:0]!=0, or the word index >= DEPTH_WORDS, the response SHALL have rsp_err=1 and rsp_data=0.
REQ-023 Otherwise the response SHALL have rsp_err=0 and rsp_data=mem[index].
REQ-024 When ld_we=1, mem[ld_idx] SHALL be written on the edge.
REQ-025 A read of the same index on that edge SHALL return the old word.
REQ-026 ld_idx >= DEPTH_WORDS SHALL be ignored.
REQ-027 Simultaneous accept, read completion and pop on one edge SHALL all take effect; occupancy SHALL change by +1, 0 or -1 accordingly.
REQ-028 With rsp_ready held at 1, one response per cycle SHALL be sustained at RSP_DEPTH>=2.
REQ-029 Queue pointers SHALL wrap modulo RSP_DEPTH.
REQ-030 Requests with req_valid=0 SHALL have no effect; req_addr is don't-care then.

Reset
REQ-031 While reset=0 at an edge: queue emptied, in-flight read discarded, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-032 In the first cycle after reset deasserts, req_ready SHALL be 1.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 ld_we SHALL still write memory while reset=0.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight responses; no stale response SHALL appear afterward.

Structure
REQ-036 A shared package SHALL hold: XLEN=64, ILEN=32, and the response record type {data[31:0], err}.
REQ-037 The response queue SHALL be one sub-module, imem_rsp_fifo, parameterised by depth and the response record; storage array and address decode stay in imem_responder.

Verification
REQ-038 Scenario 1: load mem[0..3]=0x00000013,0x00100093,0x00200113,0x00300193; request 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> four responses on consecutive cycles, first one cycle after acceptance, data in order, err=0.
REQ-039 Scenario 2: request 0x6 -> rsp_err=1, rsp_data=0; then request 0x4 -> 0x00100093, err=0.
REQ-040 Scenario 3: request 0x1000 (index 1024) at DEPTH_WORDS=1024 -> rsp_err=1, rsp_data=0.
REQ-041 Scenario 4: rsp_ready=0, issue requests -> exactly 4 accepted, then req_ready=0; rsp_data stable; raising rsp_ready drains 4 in order and req_ready returns to 1 the cycle after the first pop.
REQ-042 Scenario 5: ld_we to index 2 with 0xDEADBEEF on the same edge a read of 0x8 is accepted -> old 0x00200113 returned; a subsequent read returns 0xDEADBEEF.
REQ-043 Scenario 6: reset=0 for one edge with 3 responses pending -> rsp_valid=0 next cycle, req_ready=1, no pending response ever emerges, and mem[0] still reads 0x00000013.
